// File: rtl/voice_mixer_i2s.sv
// Mono voice mixer: sums up to 16 signed notebank voices once per frame and serialises the word on I2S.
// Define MIXER_SAT_EN for saturating results with a clip pulse; otherwise the mix wraps and clip is 0.
module voice_mixer_i2s #(
   parameter int NUM_VOICES = 4,
   parameter int BCLK_HALF  = 16
) (
   input  logic                      clk,
   input  logic                      rst_b,
   input  logic [16*NUM_VOICES-1:0]  voice_audio,
   input  logic [NUM_VOICES-1:0]     voice_done,
   output logic                      sample_req,
   output logic                      bclk,
   output logic                      lrclk,
   output logic                      sdata,
   output logic                      clip
);

   localparam int ACC_W = 20;
   localparam int DIV_W = (BCLK_HALF > 1) ? $clog2(BCLK_HALF) : 1;
   localparam int IDX_W = (NUM_VOICES > 1) ? $clog2(NUM_VOICES) : 1;

   typedef enum logic [1:0] {S_IDLE, S_ACCUM, S_SAT} state_t;

   logic [DIV_W-1:0]        r_div;
   logic                    r_bclk;
   logic [4:0]              r_bitcnt;
   logic                    r_sdata;
   logic [15:0]             r_out_word;
   logic [15:0]             r_mix_reg;
   logic                    r_sample_req;
   state_t                  r_state;
   logic signed [ACC_W-1:0] r_acc;
   logic [IDX_W-1:0]        r_idx;

   state_t                  w_state_nxt;
   logic signed [ACC_W-1:0] w_acc_nxt;
   logic [IDX_W-1:0]        w_idx_nxt;
   logic                    w_mix_load;
   logic                    w_wrap;
   logic                    w_fall;
   logic                    w_frame_start;
   logic                    w_load_word;
   logic [4:0]              w_bitcnt_nxt;
   logic [3:0]              w_bit_sel;
   logic [15:0]             w_word_nxt;
   logic signed [15:0]      w_voice [NUM_VOICES];
   logic signed [ACC_W-1:0] w_addend;
   logic [15:0]             w_result;
   logic                    w_clip_now;

   for (genvar g = 0; g < NUM_VOICES; g++) begin : g_voice
      assign w_voice[g] = voice_audio[16*g +: 16];
   end

   // Falling bclk events drive every I2S state change; the MSB trails the lrclk edge by one bit.
   assign w_wrap        = (r_div == DIV_W'(BCLK_HALF - 1));
   assign w_fall        = w_wrap & r_bclk;
   assign w_frame_start = w_fall & (r_bitcnt == 5'd31);
   assign w_load_word   = w_fall & (r_bitcnt == 5'd0);
   assign w_bitcnt_nxt  = r_bitcnt + 5'd1;
   assign w_bit_sel     = 4'd0 - w_bitcnt_nxt[3:0];
   assign w_word_nxt    = w_load_word ? r_mix_reg : r_out_word;

   always_ff @(posedge clk or negedge rst_b) begin
      if (!rst_b) begin
         r_div      <= '0;
         r_bclk     <= 1'b0;
         r_bitcnt   <= 5'd31;
         r_sdata    <= 1'b0;
         r_out_word <= '0;
      end else begin
         if (w_wrap) begin
            r_div  <= '0;
            r_bclk <= ~r_bclk;
         end else begin
            r_div  <= r_div + 1'b1;
         end
         if (w_fall) begin
            r_bitcnt   <= w_bitcnt_nxt;
            r_sdata    <= w_word_nxt[w_bit_sel];
            r_out_word <= w_word_nxt;
         end
      end
   end

   assign w_addend = voice_done[r_idx] ? '0
                   : {{(ACC_W-16){w_voice[r_idx][15]}}, w_voice[r_idx]};

   always_comb begin
      // NOTE: every signal gets a default before the case so no path can infer a latch.
      w_state_nxt = r_state;
      w_acc_nxt   = r_acc;
      w_idx_nxt   = r_idx;
      w_mix_load  = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (w_frame_start) begin
               w_acc_nxt   = '0;
               w_idx_nxt   = '0;
               w_state_nxt = S_ACCUM;
            end
         end
         S_ACCUM: begin
            w_acc_nxt = r_acc + w_addend;
            w_idx_nxt = r_idx + 1'b1;
            if (r_idx == IDX_W'(NUM_VOICES - 1)) w_state_nxt = S_SAT;
         end
         S_SAT: begin
            w_mix_load  = 1'b1;
            w_state_nxt = S_IDLE;
         end
         default: w_state_nxt = S_IDLE;
      endcase
   end

`ifdef MIXER_SAT_EN
   localparam logic signed [ACC_W-1:0] SAT_MAX = 20'sd32767;
   localparam logic signed [ACC_W-1:0] SAT_MIN = -20'sd32768;
   logic w_hi;
   logic w_lo;
   logic r_clip;

   assign w_hi       = (r_acc > SAT_MAX);
   assign w_lo       = (r_acc < SAT_MIN);
   assign w_clip_now = w_hi | w_lo;
   assign w_result   = w_hi ? 16'h7FFF : (w_lo ? 16'h8000 : r_acc[15:0]);

   always_ff @(posedge clk or negedge rst_b) begin
      if (!rst_b) r_clip <= 1'b0;
      else        r_clip <= w_mix_load & w_clip_now;
   end
   assign clip = r_clip;
`else
   logic w_unused_acc_hi;

   assign w_clip_now      = 1'b0;
   assign w_result        = r_acc[15:0];
   assign w_unused_acc_hi = ^{r_acc[ACC_W-1:16], w_clip_now};
   assign clip            = 1'b0;
`endif

   always_ff @(posedge clk or negedge rst_b) begin
      if (!rst_b) begin
         r_state      <= S_IDLE;
         r_acc        <= '0;
         r_idx        <= '0;
         r_mix_reg    <= '0;
         r_sample_req <= 1'b0;
      end else begin
         r_state      <= w_state_nxt;
         r_acc        <= w_acc_nxt;
         r_idx        <= w_idx_nxt;
         r_sample_req <= w_mix_load;
         if (w_mix_load) r_mix_reg <= w_result;
      end
   end

   assign sample_req = r_sample_req;
   assign bclk       = r_bclk;
   assign lrclk      = r_bitcnt[4];
   assign sdata      = r_sdata;

endmodule

// File: tb/tb_voice_mixer_i2s.sv
// Scoreboard bench for voice_mixer_i2s: directed mixes are queued as expected I2S words and an
// independent deserialiser pops and compares each completed channel word.
`timescale 1ns/1ps
module tb_voice_mixer_i2s;

   localparam int NV = 4;
   localparam int BH = 16;

   logic          clk = 1'b0;
   logic          rst_b = 1'b0;
   logic [16*NV-1:0] voice_audio;
   logic [NV-1:0] voice_done;
   logic          sample_req;
   logic          bclk;
   logic          lrclk;
   logic          sdata;
   logic          clip;

   voice_mixer_i2s #(.NUM_VOICES(NV), .BCLK_HALF(BH)) dut (
      .clk         (clk),
      .rst_b       (rst_b),
      .voice_audio (voice_audio),
      .voice_done  (voice_done),
      .sample_req  (sample_req),
      .bclk        (bclk),
      .lrclk       (lrclk),
      .sdata       (sdata),
      .clip        (clip)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic        ch;
      logic [15:0] word;
   } exp_t;

   exp_t exp_q[$];
   int   total = 0;
   int   bad   = 0;
   logic exp_clip = 1'b0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      total++;
      if (act !== req) begin
         bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, req, $time);
      end
   endtask

   task automatic apply(input logic [15:0] v0, input logic [15:0] v1, input logic [15:0] v2,
                        input logic [15:0] v3, input logic [3:0] done);
      voice_audio = {v3, v2, v1, v0};
      voice_done  = done;
   endtask

   task automatic push_word(input logic [15:0] w, input logic c);
      exp_t e;
      e.ch = 1'b0; e.word = w; exp_q.push_back(e);
      e.ch = 1'b1; e.word = w; exp_q.push_back(e);
      exp_clip = c;
   endtask

   task automatic check_reset_outputs(input string name);
      check({name, "_bclk"},  {31'b0, bclk},       32'd0);
      check({name, "_lrclk"}, {31'b0, lrclk},      32'd1);
      check({name, "_sdata"}, {31'b0, sdata},      32'd0);
      check({name, "_sreq"},  {31'b0, sample_req}, 32'd0);
      check({name, "_clip"},  {31'b0, clip},       32'd0);
   endtask

   task automatic wait_sreq(input string name);
      int n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!sample_req && n < 3000);
      check({name, "_sreq_seen"}, {31'b0, sample_req}, 32'd1);
      check({name, "_clip"},      {31'b0, clip},       {31'b0, exp_clip});
   endtask

   // Called at a negedge with rst_b just released; measures lrclk fall and first sample_req.
   task automatic release_timing(input string name);
      int   n    = 0;
      int   t_lr = -1;
      int   t_sr = -1;
      logic lsb  = 1'b1;
      while (t_sr < 0 && n < 200) begin
         @(negedge clk);
         n++;
         if (t_lr < 0 && !lrclk) begin
            t_lr = n;
            lsb  = sdata;
         end
         if (sample_req) t_sr = n;
      end
      check({name, "_lr_fall"},  t_lr, 2*BH);
      check({name, "_lsb_slot"}, {31'b0, lsb}, 32'd0);
      check({name, "_sreq_at"},  t_sr, 2*BH + NV + 1);
      check({name, "_clip"},     {31'b0, clip}, {31'b0, exp_clip});
   endtask

   // I2S deserialiser: a word completes on the bit where lrclk changes (LSB shares that slot).
   initial begin : monitor
      logic        prev_bclk = 1'b0;
      logic        prev_lr   = 1'b1;
      logic [15:0] sh        = '0;
      int          cnt       = 0;
      exp_t        e;
      forever begin
         @(negedge clk);
         if (!rst_b) begin
            prev_bclk = 1'b0;
            prev_lr   = 1'b1;
            cnt       = 0;
         end else begin
            if (bclk && !prev_bclk) begin
               sh = {sh[14:0], sdata};
               cnt++;
               if (lrclk != prev_lr) begin
                  if (cnt == 16 && exp_q.size() > 0) begin
                     e = exp_q.pop_front();
                     check("word_channel", {31'b0, prev_lr}, {31'b0, e.ch});
                     check("word_value",   {16'b0, sh},      {16'b0, e.word});
                  end
                  cnt = 0;
               end
               prev_lr = lrclk;
            end
            prev_bclk = bclk;
         end
      end
   end

   initial begin : period_checker
      int   cnt   = 0;
      logic valid = 1'b0;
      forever begin
         @(negedge clk);
         if (!rst_b) begin
            cnt   = 0;
            valid = 1'b0;
         end else begin
            cnt++;
            if (sample_req) begin
               if (valid) check("sreq_period", cnt, 64*BH);
               valid = 1'b1;
               cnt   = 0;
            end
         end
      end
   end

   initial begin : stimulus
      int   n;
      logic lr_prev;

      rst_b = 1'b0;
      apply(16'h1234, 16'h7777, 16'h5555, 16'hFFFF, 4'b1110);
      repeat (4) @(negedge clk);
      check_reset_outputs("reset1");
      push_word(16'h1234, 1'b0);
      rst_b = 1'b1;
      release_timing("rst1");

      apply(16'h3000, 16'h3000, 16'h3000, 16'h3000, 4'b0000);
`ifdef MIXER_SAT_EN
      push_word(16'h7FFF, 1'b1);
`else
      push_word(16'hC000, 1'b0);
`endif
      wait_sreq("mix_3000x4");

      apply(16'hA000, 16'hA000, 16'h1111, 16'h2222, 4'b1100);
`ifdef MIXER_SAT_EN
      push_word(16'h8000, 1'b1);
`else
      push_word(16'h4000, 1'b0);
`endif
      wait_sreq("mix_a000x2");

      apply(16'h0100, 16'hFF00, 16'h0005, 16'h0003, 4'b0000);
      push_word(16'h0008, 1'b0);
      wait_sreq("mix_sum8");

      apply(16'h0100, 16'hFF00, 16'h0005, 16'h0003, 4'b0001);
      push_word(16'hFF08, 1'b0);
      wait_sreq("mix_done0");

      apply(16'h0011, 16'h0022, 16'h0033, 16'h0005, 4'b0000);
      push_word(16'h006B, 1'b0);
      wait_sreq("mix_odd");

      // Next mix: 0x7FFF + 1, reset will strike during its accumulation.
      apply(16'h7FFF, 16'h0001, 16'h4000, 16'h4000, 4'b1100);
      n = 0;
      lr_prev = lrclk;
      do begin
         @(negedge clk);
         n++;
         if (lr_prev && !lrclk) break;
         lr_prev = lrclk;
      end while (n < 3000);
      check("frame_start_seen", {31'b0, lrclk}, 32'd0);
      repeat (2) @(negedge clk);
      check("pending_right_word", exp_q.size(), 32'd1);
      if (exp_q.size() > 0) void'(exp_q.pop_back());
      rst_b = 1'b0;
      #1;
      check_reset_outputs("reset2_async");
      repeat (3) @(negedge clk);
      check_reset_outputs("reset2_held");
`ifdef MIXER_SAT_EN
      push_word(16'h7FFF, 1'b1);
`else
      push_word(16'h8000, 1'b0);
`endif
      rst_b = 1'b1;
      release_timing("rst2");

      n = 0;
      while (exp_q.size() > 0 && n < 3000) begin
         @(negedge clk);
         n++;
      end
      check("queue_drained", exp_q.size(), 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/voice_mixer_i2s.md
# voice_mixer_i2s

Downstream stage of the notebank voice array. Once per audio frame it sums the signed 16-bit samples of up to 16 notebank voices, skipping voices that report `done`. It saturates the sum to 16 bits and serialises the result as mono (same word on left and right) onto a standard I2S link to the codec DAC. It also issues a one-cycle `sample_req` strobe that tells the notebanks to advance to their next sample.

## Interface
Parameters:
- `NUM_VOICES`, default 4: number of notebank voices mixed; legal range 1..16.
- `BCLK_HALF`, default 16: clk cycles per half bit-clock period. Sample rate is clk / (64·BCLK_HALF). Must satisfy 2·BCLK_HALF ≥ NUM_VOICES + 3.

Ports:
- `clk` input 1: system clock; all logic on rising edge.
- `rst_b` input 1: asynchronous, active-low reset.
- `voice_audio` input 16·NUM_VOICES: packed signed two's-complement samples; voice i occupies bits [16i+15:16i].
- `voice_done` input NUM_VOICES: 1 means the voice is silent and contributes 0.
- `sample_req` output 1: one-cycle pulse; notebanks may update `voice_audio` only after it.
- `bclk` output 1: I2S bit clock.
- `lrclk` output 1: I2S word select; 0 = left, 1 = right.
- `sdata` output 1: I2S serial data, MSB first.
- `clip` output 1: one-cycle pulse when the current mix saturated (`MIXER_SAT_EN` only; tied 0 otherwise).

## Operation
- Divider counts 0..BCLK_HALF-1. At each wrap `bclk` toggles. A wrap that drives `bclk` 1→0 is a "falling event".
- `bitcnt` (5 bit) increments mod 32 on each falling event. `lrclk` = `bitcnt`[4]. Both update on the falling event.
- `sdata` = `out_word`[(-bitcnt) mod 16], updated on the falling event:
  - `bitcnt` 1 carries bit 15 and `bitcnt` 16 carries bit 0 (left channel).
  - `bitcnt` 17 carries bit 15 and `bitcnt` 0 carries bit 0 (right channel).
  - This is standard I2S with a one-bclk MSB delay.
- `out_word` loads `mix_reg` on the falling event where `bitcnt` goes 0→1.
- Frame start is the falling event where `bitcnt` goes 31→0. Mix FSM:
  - IDLE: wait for frame start, then clear the accumulator (ACC_W = 20 bits signed), set i=0, go to ACCUM.
  - ACCUM: one voice per cycle. If `voice_done`[i]=0, add sign-extended `voice_audio`[i] to the accumulator. Advance i. After voice NUM_VOICES-1 go to SAT.
  - SAT: write the 16-bit result to `mix_reg`, assert `sample_req` for exactly this cycle, return to IDLE.
- `voice_audio` and `voice_done` must be stable from frame start until `sample_req`. The notebanks obey this by advancing only on `sample_req`.
- Arithmetic: the accumulator cannot overflow for 16 voices. The result rule depends on `MIXER_SAT_EN` (see Configuration).

## Timing
- Reset values:
  - `bclk`=0, `lrclk`=1, `sdata`=0, `sample_req`=0, `clip`=0.
  - `bitcnt`=31, divider=0, `out_word`=0, `mix_reg`=0, FSM=IDLE.
- After reset release, the first frame start occurs on the first falling event, 2·BCLK_HALF cycles after release.
- ACCUM takes NUM_VOICES cycles and SAT takes 1 cycle. `sample_req` fires NUM_VOICES+1 cycles after frame start.
- A mix lands in `mix_reg` before `bitcnt` 0→1 and goes out in the same frame. Its MSB appears on `sdata` one bclk period after `lrclk` falls.
- `sample_req` fires exactly once per frame, every 64·BCLK_HALF cycles.
- Reset asserted mid-frame or mid-ACCUM: all state returns to reset values immediately and no `sample_req` is emitted. The partial mix is discarded.

## Configuration
- `MIXER_SAT_EN` defined:
  - Sums above 32767 become 0x7FFF; sums below −32768 become 0x8000.
  - `clip` pulses in the SAT cycle of any clipped mix.
- `MIXER_SAT_EN` undefined:
  - The result is the accumulator's low 16 bits (wrap-around).
  - `clip` is constant 0.

## Test plan
- Reset: hold `rst_b`=0 → `bclk`=0, `lrclk`=1, `sdata`=0, `sample_req`=0. After release, first `lrclk` fall occurs 2·BCLK_HALF cycles later.
- Voice0=0x1234, voices1-3 done → both channels serialise 0x1234 MSB first, starting one bclk after each `lrclk` edge. Exactly one `sample_req` per 1024 cycles (BCLK_HALF=16).
- Four voices 0x3000 each:
  - With macro: word 0x7FFF and one `clip` pulse.
  - Without macro: word 0xC000 and `clip`=0.
- Voices 0xA000 and 0xA000, others done:
  - With macro: 0x8000.
  - Without macro: 0x4000.
- Voices 0x0100, 0xFF00, 0x0005, 0x0003 (sum 8) → word 0x0008. Then set voice_done[0]=1 after `sample_req` → next frame word 0xFF08.
- Pulse `rst_b` low during ACCUM → no `sample_req` that frame, outputs at reset values, `out_word` 0 for the next frame's LSB slot, normal mixing resumes.
